// File: rtl/conv_stride_engine.sv
// conv_stride_engine: strided 2-D convolution of an R x C input with a K x K
// kernel plus bias. Taps are fetched from external 1-cycle-latency memories
// and accumulated through a multiply pipeline. Results leave through a small
// FIFO on an AXI-Stream master port.
// Optional build macro ZERO_PAD_EN adds the pad_en port and (K-1)/2 zero
// padding for odd K.
module conv_stride_engine #(
  parameter int INW    = 18,
  parameter int R      = 8,
  parameter int C      = 8,
  parameter int MAXK   = 5,
  parameter int MAXS   = 2,
  parameter int ODEPTH = 4,
  localparam int OUTW  = $clog2(64'(MAXK * MAXK) * (64'd1 << (2 * INW - 2)) + (64'd1 << (INW - 1))) + 1,
  localparam int KW    = $clog2(MAXK + 1),
  localparam int SW    = $clog2(MAXS + 1),
  localparam int XAW   = $clog2(R * C),
  localparam int WAW   = $clog2(MAXK * MAXK)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
`ifdef ZERO_PAD_EN
  input  logic                  pad_en,
`endif
  input  logic [KW-1:0]         K,
  input  logic [SW-1:0]         S,
  input  logic signed [INW-1:0] B,
  output logic [XAW-1:0]        X_read_addr,
  input  logic signed [INW-1:0] X_data,
  output logic [WAW-1:0]        W_read_addr,
  input  logic signed [INW-1:0] W_data,
  output logic                  busy,
  output logic                  done,
  output logic [OUTW-1:0]       OUTPUT_TDATA,
  output logic                  OUTPUT_TVALID,
  input  logic                  OUTPUT_TREADY
);
  localparam int PW     = (ODEPTH > 1) ? $clog2(ODEPTH) : 1;
  localparam int CW     = $clog2(ODEPTH + 1);
  localparam int OW     = $clog2(((R > C) ? R : C) + 2 * MAXK + 1);
  localparam int PRW    = 2 * INW;
  localparam int STAGES = 1;

  typedef enum logic [2:0] {IDLE, INIT, MAC, DRAIN, PUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [KW-1:0]         k_r, tap_i, tap_j;
  logic [SW-1:0]         s_r;
  logic signed [INW-1:0] b_r;
  logic                  pad_r;
  logic [OW-1:0]         out_r, out_c;
  logic [1:0]            dcnt;
  logic [STAGES:0]       vld_pipe;
  logic                  pad_d;
  logic signed [PRW-1:0] prod;
  logic signed [OUTW-1:0] acc;

  int   pp, row, col;
  logic issue, pad_tap, last_tap, last_col, last_row, legal;

  logic [OUTW-1:0] mem [ODEPTH];
  logic [PW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  logic            full, push, pop;

  // Window geometry: current tap coordinates, padding test and end-of-grid flags.
  always_comb begin
    pp = 0;
`ifdef ZERO_PAD_EN
    if (pad_r) pp = int'(k_r) / 2;
`endif
    row = int'(out_r) * int'(s_r) + int'(tap_i) - pp;
    col = int'(out_c) * int'(s_r) + int'(tap_j) - pp;
    pad_tap = 1'b0;
`ifdef ZERO_PAD_EN
    pad_tap = (row < 0) || (row >= R) || (col < 0) || (col >= C);
`endif
    issue    = (state == MAC);
    last_tap = (int'(tap_i) == int'(k_r) - 1) && (int'(tap_j) == int'(k_r) - 1);
    last_col = (int'(out_c) + 1) * int'(s_r) + int'(k_r) > C + 2 * pp;
    last_row = (int'(out_r) + 1) * int'(s_r) + int'(k_r) > R + 2 * pp;
    legal    = (k_r != '0) && (s_r != '0) && (int'(k_r) <= R) && (int'(k_r) <= C) &&
               (int'(k_r) <= MAXK) && (int'(s_r) <= MAXS);
    X_read_addr = (issue && !pad_tap) ? XAW'(row * C + col) : '0;
    W_read_addr = issue ? WAW'(int'(tap_i) * int'(k_r) + int'(tap_j)) : '0;
  end

  // FIFO handshake; a full FIFO still takes a push when it pops the same cycle.
  always_comb begin
    pop           = OUTPUT_TVALID && OUTPUT_TREADY;
    full          = (cnt == CW'(ODEPTH));
    push          = (state == PUSH) && (!full || pop);
    OUTPUT_TVALID = (cnt != '0);
    OUTPUT_TDATA  = mem[rp];
    busy          = (state != IDLE);
    done          = (state == DONE);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = legal ? MAC : DONE;
      MAC:     if (last_tap) state_nxt = DRAIN;
      DRAIN:   if (dcnt == 2'd2) state_nxt = PUSH;
      PUSH:    if (push) state_nxt = (last_col && last_row) ? DONE : INIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Run configuration capture plus output-position, tap and drain counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_r <= '0; s_r <= '0; b_r <= '0; pad_r <= 1'b0;
      out_r <= '0; out_c <= '0; tap_i <= '0; tap_j <= '0; dcnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k_r <= K; s_r <= S; b_r <= B;
`ifdef ZERO_PAD_EN
          pad_r <= pad_en & K[0];
`else
          pad_r <= 1'b0;
`endif
          out_r <= '0; out_c <= '0;
        end
        INIT: begin
          tap_i <= '0; tap_j <= '0; dcnt <= '0;
        end
        MAC: begin
          if (int'(tap_j) == int'(k_r) - 1) begin
            tap_j <= '0;
            tap_i <= tap_i + 1'b1;
          end else begin
            tap_j <= tap_j + 1'b1;
          end
        end
        DRAIN: dcnt <= dcnt + 1'b1;
        PUSH: if (push) begin
          if (last_col) begin
            out_c <= '0;
            out_r <= out_r + 1'b1;
          end else begin
            out_c <= out_c + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // MAC pipeline: data arrives the cycle after issue, product registered,
  // then accumulated. Padding taps carry a zero product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0; pad_d <= 1'b0; prod <= '0; acc <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      pad_d    <= pad_tap;
      if (vld_pipe[0]) prod <= pad_d ? '0 : X_data * W_data;
      if (state == INIT)
        acc <= {{(OUTW-INW){b_r[INW-1]}}, b_r};
      else if (vld_pipe[STAGES])
        acc <= acc + {{(OUTW-PRW){prod[PRW-1]}}, prod};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0; rp <= '0; cnt <= '0;
    end else begin
      if (push) wp <= (wp == PW'(ODEPTH - 1)) ? '0 : wp + 1'b1;
      if (pop)  rp <= (rp == PW'(ODEPTH - 1)) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are don't-care while cnt is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= acc;
  end
endmodule

// File: doc/conv_stride_engine.md
CONV_STRIDE_ENGINE -- requirements
Module: conv_stride_engine

Interface
REQ-001 Parameter INW, default 18, signed data width of X, W and B.
REQ-002 Parameter R, default 8, rows of X; parameter C, default 8, columns of X.
REQ-003 Parameter MAXK, default 5, largest kernel edge; parameter MAXS, default 2, largest stride.
REQ-004 Parameter ODEPTH, default 4, output FIFO entries (>=2).
REQ-005 Localparam OUTW = $clog2(MAXK*MAXK*2^(2*INW-2) + 2^(INW-1)) + 1.
REQ-006 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-007 Port reset, input, 1, asynchronous active-high reset.
REQ-008 Port start, input, 1, begin one convolution run when idle.
REQ-009 Ports K (input, $clog2(MAXK+1)) and S (input, $clog2(MAXS+1)), kernel edge and stride, sampled on accepted start.
REQ-010 Port B, input, INW, signed bias, sampled on accepted start.
REQ-011 Ports X_read_addr (output, $clog2(R*C)) and X_data (input, INW); external memory, 1-cycle read latency.
REQ-012 Ports W_read_addr (output, $clog2(MAXK*MAXK)) and W_data (input, INW); row-major K*K, 1-cycle read latency.
REQ-013 Ports busy (output, 1), high from accepted start to done; done (output, 1), one-cycle pulse at end of run.
REQ-014 Ports OUTPUT_TDATA (output, OUTW), OUTPUT_TVALID (output, 1), OUTPUT_TREADY (input, 1), AXI-Stream master.
REQ-015 Port pad_en, input, 1, sampled on start; present only when ZERO_PAD_EN is defined.

Function
REQ-016 start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-017 States SHALL be IDLE, INIT, MAC, DRAIN, PUSH, DONE; IDLE->INIT on start, INIT->MAC, MAC->DRAIN after K*K issues, DRAIN->PUSH after 3 cycles, PUSH->INIT (more outputs) or DONE (last), DONE->IDLE.
REQ-018 Output grid: Rout = floor((R-K)/S)+1, Cout = floor((C-K)/S)+1, emitted row-major.
REQ-019 Output (r,c) SHALL equal B + sum over i,j<K of X[r*S+i][c*S+j]*W[i][j], signed, sign-extended to OUTW, no saturation.
REQ-020 MAC SHALL be pipelined: address cycle t, data t+1, registered product t+2, accumulate t+3; one tap issued per cycle in MAC, no bubbles.
REQ-021 INIT SHALL load accumulator with sign-extended B; per-output latency SHALL be exactly K*K+5 cycles when FIFO not full.
REQ-022 PUSH SHALL write one word to the internal ODEPTH FIFO; if full, SHALL stall in PUSH until space exists.
REQ-023 FIFO SHALL accept push and pop in the same cycle when full; OUTPUT_TDATA SHALL stay stable while TVALID high and TREADY low.
REQ-024 done SHALL pulse after the last output is written to the FIFO (not necessarily drained).
REQ-025 Illegal config (K=0, S=0, K>R, K>C, K>MAXK, S>MAXS) SHALL produce no outputs and pulse done 2 cycles after start.
REQ-026 Addresses SHALL be X_read_addr = (r*S+i)*C + (c*S+j), W_read_addr = i*K+j.

Reset
REQ-027 Reset SHALL force IDLE, busy=0, done=0, OUTPUT_TVALID=0, FIFO empty, all counters and accumulator 0, addresses 0.
REQ-028 Reset mid-run SHALL abandon the run immediately; no partial output SHALL appear after reset release.

Configuration
REQ-029 Macro ZERO_PAD_EN: when defined, pad_en=1 with odd K applies P=(K-1)/2 zero padding, Rout=floor((R+2P-K)/S)+1, Cout likewise.
REQ-030 With ZERO_PAD_EN, out-of-range taps SHALL contribute exactly 0 (issue cycle consumed, X_read_addr held 0); pad_en=1 with even K SHALL be treated as pad_en=0.
REQ-031 Without ZERO_PAD_EN, pad_en port and padding logic SHALL be absent; behaviour is REQ-018 only.

Verification
REQ-032 R=C=8, K=3, S=1, X=all 1, W=all 1, B=2 -> 36 outputs, each 11, done once.
REQ-033 K=3, S=2, X[i][j]=8i+j, W=identity-centre (W[1][1]=1), B=0 -> 9 outputs 9,11,13,25,27,29,41,43,45.
REQ-034 K=5, S=1, X=W=-2^(INW-1), B=-2^(INW-1) -> 16 outputs equal 25*2^(2*INW-2)-2^(INW-1), no overflow.
REQ-035 OUTPUT_TREADY=0 for 50 cycles during K=2,S=1 run -> exactly ODEPTH words held, engine stalls in PUSH, no loss/duplication after release.
REQ-036 K=6 on R=C=8 with MAXK=5 -> zero outputs, done 2 cycles after start; reset asserted mid-run -> TVALID=0, IDLE, next run correct.
REQ-037 ZERO_PAD_EN, pad_en=1, K=3, S=1, X=all 1, W=all 1, B=0 -> 64 outputs: corners 4, edges 6, interior 9.
